// File: rtl/store_buffer_if.sv
// Core/dmem side signals of the posted-write store buffer.
// slave: the buffer itself; master: the core and dmem that surround it.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    logic                       st_valid;
    logic [AW-1:0]              st_addr;
    logic [DW-1:0]              st_data;
    logic [DW/8-1:0]            st_be;
    logic                       st_ready;
    logic                       ld_valid;
    logic [AW-1:0]              ld_addr;
    logic                       ld_stall;
    logic                       ld_fwd_valid;
    logic [DW-1:0]              ld_fwd_data;
    logic                       mem_we;
    logic [AW-1:0]              mem_addr;
    logic [DW-1:0]              mem_wd;
    logic [DW/8-1:0]            mem_be;
    logic                       mem_ready;
    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ready,
        output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
               mem_we, mem_addr, mem_wd, mem_be, count
    );
    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ready,
        input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
               mem_we, mem_addr, mem_wd, mem_be, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and dmem, with load hazard detection.
// Define STB_FWD_EN to forward full-word stores to matching loads instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_match;
    entry_t          w_head;
    logic            w_unused;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = sb.st_valid && !w_full;
    assign w_pop   = !w_empty && sb.mem_ready;
    assign w_head  = r_mem[r_rd_ptr];

    assign sb.st_ready = !w_full;
    assign sb.count    = r_count;
    assign sb.mem_we   = !w_empty;
    assign sb.mem_addr = w_empty ? '0 : w_head.addr;
    assign sb.mem_wd   = w_empty ? '0 : w_head.data;
    assign sb.mem_be   = w_empty ? '0 : w_head.be;

    // Word-granular hazard check: the low two address bits never participate.
    assign w_unused = &{1'b0, sb.ld_addr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents are don't-care outside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{addr: sb.st_addr, data: sb.st_data, be: sb.st_be};
    end

`ifdef STB_FWD_EN
    logic [PW-1:0] w_young;
    logic          w_young_full;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_match = 1'b0;
        w_young = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_mem[r_rd_ptr + PW'(k)].addr[AW-1:2] == sb.ld_addr[AW-1:2])) begin
                w_match = 1'b1;
                w_young = r_rd_ptr + PW'(k);
            end
        end
    end

    assign w_young_full    = &r_mem[w_young].be;
    assign sb.ld_stall     = sb.ld_valid && w_match && !w_young_full;
    assign sb.ld_fwd_valid = sb.ld_valid && w_match && w_young_full;
    assign sb.ld_fwd_data  = sb.ld_fwd_valid ? r_mem[w_young].data : '0;
`else
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) &&
                (r_mem[r_rd_ptr + PW'(k)].addr[AW-1:2] == sb.ld_addr[AW-1:2]))
                w_match = 1'b1;
        end
    end

    assign sb.ld_stall     = sb.ld_valid && w_match;
    assign sb.ld_fwd_valid = 1'b0;
    assign sb.ld_fwd_data  = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard on the dmem port plus
// directed hazard checks; expectations track the STB_FWD_EN build option.
module tb_store_buffer;
    localparam int AW = 32, DW = 32, DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } st_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    st_t  exp_q [$];

    store_buffer_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) sbif ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .sb    (sbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Handshakes are decided at the next posedge; inputs change at posedge+1,
    // so the negedge sees the values that edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sbif.mem_we && sbif.mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_wr", sbif.mem_we, 0);
                end else begin
                    st_t e;
                    e = exp_q.pop_front();
                    chk("mem_addr", sbif.mem_addr, e.addr);
                    chk("mem_wd", sbif.mem_wd, e.data);
                    chk("mem_be", sbif.mem_be, e.be);
                end
            end
            if (sbif.st_valid && sbif.st_ready)
                exp_q.push_back('{addr: sbif.st_addr, data: sbif.st_data, be: sbif.st_be});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        sbif.st_valid = 1'b1;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        sbif.st_be    = be;
        step();
        sbif.st_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        sbif.mem_ready = 1'b1;
        n = 0;
        while (sbif.count != 0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, sbif.count, 0);
        chk({tag, "_q"}, exp_q.size(), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sbif.st_valid = 1'b0; sbif.st_addr = '0; sbif.st_data = '0; sbif.st_be = '0;
        sbif.ld_valid = 1'b0; sbif.ld_addr = '0; sbif.mem_ready = 1'b0;
        step(); step();
        chk("rst_count", sbif.count, 0);
        chk("rst_mem_we", sbif.mem_we, 0);
        chk("rst_st_ready", sbif.st_ready, 1);
        chk("rst_ld_stall", sbif.ld_stall, 0);
        chk("rst_fwd_valid", sbif.ld_fwd_valid, 0);
        chk("rst_fwd_data", sbif.ld_fwd_data, 0);
        rst_n = 1'b1;
        step();

        // Fill with dmem blocked; a fifth store must be dropped.
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        chk("full_count", sbif.count, 4);
        chk("full_st_ready", sbif.st_ready, 0);
        chk("full_mem_addr", sbif.mem_addr, 32'h100);
        push(32'h110, 32'hBAD0_BAD0, 4'hF);
        chk("drop_count", sbif.count, 4);
        chk("drop_mem_addr", sbif.mem_addr, 32'h100);
        drain("fill_drain");

        // Streaming: push and pop every cycle keeps one entry resident.
        sbif.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sbif.st_valid = 1'b1;
            sbif.st_addr  = 32'h180 + 32'(4 * i);
            sbif.st_data  = 32'h5100 + 32'(i);
            sbif.st_be    = 4'(i + 1);
            step();
            chk("stream_count", sbif.count, 1);
        end
        sbif.st_valid = 1'b0;
        step();
        chk("stream_end_count", sbif.count, 0);

        // Full-word store hazard, held across the popping cycle.
        sbif.mem_ready = 1'b0;
        push(32'h200, 32'hDEAD_BEEF, 4'hF);
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h202;
        #1;
`ifdef STB_FWD_EN
        chk("sw_fwd_valid", sbif.ld_fwd_valid, 1);
        chk("sw_fwd_data", sbif.ld_fwd_data, 32'hDEAD_BEEF);
        chk("sw_stall", sbif.ld_stall, 0);
`else
        chk("sw_stall", sbif.ld_stall, 1);
        chk("sw_fwd_valid", sbif.ld_fwd_valid, 0);
        chk("sw_fwd_data", sbif.ld_fwd_data, 0);
`endif
        step(); step();
        sbif.mem_ready = 1'b1;
        #1;
`ifdef STB_FWD_EN
        chk("pop_cycle_fwd", sbif.ld_fwd_valid, 1);
`else
        chk("pop_cycle_stall", sbif.ld_stall, 1);
`endif
        step();
        chk("after_pop_stall", sbif.ld_stall, 0);
        chk("after_pop_fwd", sbif.ld_fwd_valid, 0);

        // A store pushed this cycle is not yet a hazard.
        sbif.ld_addr  = 32'h400;
        sbif.st_valid = 1'b1; sbif.st_addr = 32'h400; sbif.st_data = 32'h4444_0000; sbif.st_be = 4'hF;
        sbif.mem_ready = 1'b0;
        #1;
        chk("same_cycle_stall", sbif.ld_stall, 0);
        step();
        sbif.st_valid = 1'b0;
        sbif.ld_valid = 1'b0;
        #1;
        chk("no_ld_valid_stall", sbif.ld_stall, 0);
        drain("haz_drain");

        // Partial store always stalls; another word does not.
        sbif.mem_ready = 1'b0;
        push(32'h300, 32'h0000_AB00, 4'b0010);
        sbif.ld_valid = 1'b1;
        sbif.ld_addr  = 32'h300;
        #1;
        chk("sb_stall", sbif.ld_stall, 1);
        chk("sb_fwd_valid", sbif.ld_fwd_valid, 0);
        sbif.ld_addr = 32'h304;
        #1;
        chk("sb_other_stall", sbif.ld_stall, 0);
        sbif.ld_addr = 32'h300;
        push(32'h300, 32'h1122_3344, 4'hF);
        #1;
`ifdef STB_FWD_EN
        chk("young_fwd_valid", sbif.ld_fwd_valid, 1);
        chk("young_fwd_data", sbif.ld_fwd_data, 32'h1122_3344);
        chk("young_stall", sbif.ld_stall, 0);
`else
        chk("young_stall", sbif.ld_stall, 1);
`endif
        sbif.ld_valid = 1'b0;
        drain("sb_drain");

        // Pointer wrap: keep three resident, then nine simultaneous push/pop.
        sbif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), $urandom, 4'(i + 3));
        sbif.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sbif.st_valid = 1'b1;
            sbif.st_addr  = 32'h700 + 32'(4 * i);
            sbif.st_data  = $urandom;
            sbif.st_be    = 4'(i);
            step();
        end
        sbif.st_valid = 1'b0;
        chk("wrap_count", sbif.count, 3);
        drain("wrap_drain");

        // Reset in the middle of a drain discards everything.
        sbif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h800 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
        chk("pre_rst_count", sbif.count, 3);
        sbif.mem_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        chk("mid_rst_count", sbif.count, 0);
        chk("mid_rst_mem_we", sbif.mem_we, 0);
        chk("mid_rst_st_ready", sbif.st_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_mem_we", sbif.mem_we, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
